imem_responder: RTL and testbench

Instruction-memory responder serving word fetch requests issued by the multi-cycle CPU's fetch stage over a valid/ready request/response handshake. It holds the program in a word-addressed array, returns each requested word after a fixed, parameterised latency, and flags misaligned or out-of-range addresses. A side load port lets the testbench or a boot loader write program words before or during execution.

---
 rtl/imem_responder_pkg.sv | 13 +
 rtl/imem_responder_if.sv | 22 ++
 rtl/imem_responder_array.sv | 38 +++
 rtl/imem_responder.sv | 97 +++++++++
 tb/tb_imem_responder.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder and its CPU-side users.
// The fetch stage decoder reuses NOP_INSN as its bubble instruction.
package imem_responder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/imem_responder_if.sv
// Fetch request/response channel between the CPU fetch stage (master) and the responder (slave).
// Handshake: a transfer happens on a posedge where VALID and READY are both high; the
// sender holds VALID and its payload stable until that edge, and READY may depend on state only.
interface imem_responder_if;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [31:0] REQ_ADDR;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [31:0] RSP_DATA;
  logic        RSP_ERR;

  modport master (
    output REQ_VALID, REQ_ADDR, RSP_READY,
    input  REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR
  );

  modport slave (
    input  REQ_VALID, REQ_ADDR, RSP_READY,
    output REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR
  );
endinterface

// File: rtl/imem_responder_array.sv
// DEPTH x 32 program store: one write port, one registered read port.
// A write to the word being read on the same edge returns the old contents.
module imem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_d;
  logic [31:0] rdata_q;

  // Program words survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts one fetch at a time, answers LATENCY edges later,
// and substitutes a NOP with RSP_ERR for misaligned or out-of-range byte addresses.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  imem_responder_if.slave          bus,
  input  logic                     LOAD_EN,
  input  logic [$clog2(DEPTH)-1:0] LOAD_ADDR,
  input  logic [31:0]              LOAD_DATA,
  output state_e                   dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e        state_d, state_q;
  logic [CW-1:0] cnt_d,   cnt_q;
  logic [31:0]   addr_d,  addr_q;
  logic          err_d,   err_q;
  logic          rd_en;
  logic          addr_err;
  logic [31:0]   rd_data;

  assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q[31:AW+2] != '0);

  // The counter holds the remaining wait edges; the read is captured on the edge where it
  // is already zero, so the response appears exactly LATENCY edges after acceptance.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    err_d   = err_q;
    rd_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.REQ_VALID) begin
          addr_d  = bus.REQ_ADDR;
          cnt_d   = CW'(LATENCY - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          rd_en   = 1'b1;
          err_d   = addr_err;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP: begin
        if (bus.RSP_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  imem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (CLK),
    .rst   (RST),
    .we    (LOAD_EN),
    .waddr (LOAD_ADDR),
    .wdata (LOAD_DATA),
    .re    (rd_en),
    .raddr (addr_q[AW+1:2]),
    .rdata (rd_data)
  );

  assign bus.REQ_READY = (state_q == S_IDLE) && !RST;
  assign bus.RSP_VALID = (state_q == S_RESP);
  assign bus.RSP_DATA  = err_q ? NOP_INSN : rd_data;
  assign bus.RSP_ERR   = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: a LATENCY=2 instance for functional cases and a
// LATENCY=1 instance for back-to-back throughput.
module tb_imem_responder;
  import imem_responder_pkg::*;

  localparam int DEPTH = 256;
  localparam int AW    = $clog2(DEPTH);

  logic CLK;
  logic RST;
  int   checks;
  int   errors;
  int   cyc;

  logic          a_load_en,   b_load_en;
  logic [AW-1:0] a_load_addr, b_load_addr;
  logic [31:0]   a_load_data, b_load_data;
  state_e        a_state,     b_state;

  imem_responder_if ifa ();
  imem_responder_if ifb ();

  imem_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut_a (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (ifa.slave),
    .LOAD_EN   (a_load_en),
    .LOAD_ADDR (a_load_addr),
    .LOAD_DATA (a_load_data),
    .dbg_state (a_state)
  );

  imem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut_b (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (ifb.slave),
    .LOAD_EN   (b_load_en),
    .LOAD_ADDR (b_load_addr),
    .LOAD_DATA (b_load_data),
    .dbg_state (b_state)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] prog_word(input int i);
    return 32'hB000_0000 + 32'(i) * 32'h0000_0101;
  endfunction

  // Driver tasks
  task automatic set_req(input bit sel_b, input logic v, input logic [31:0] a);
    if (sel_b) begin
      ifb.REQ_VALID = v;
      ifb.REQ_ADDR  = a;
    end else begin
      ifa.REQ_VALID = v;
      ifa.REQ_ADDR  = a;
    end
  endtask

  function automatic logic obs_valid(input bit sel_b);
    return sel_b ? ifb.RSP_VALID : ifa.RSP_VALID;
  endfunction

  function automatic logic obs_ready(input bit sel_b);
    return sel_b ? ifb.REQ_READY : ifa.REQ_READY;
  endfunction

  function automatic logic [31:0] obs_data(input bit sel_b);
    return sel_b ? ifb.RSP_DATA : ifa.RSP_DATA;
  endfunction

  function automatic logic obs_err(input bit sel_b);
    return sel_b ? ifb.RSP_ERR : ifa.RSP_ERR;
  endfunction

  // One complete fetch with RSP_READY held high: accept, wait (bounded), handshake.
  task automatic fetch(input bit sel_b, input logic [31:0] addr, input logic [31:0] exp_d,
                       input logic exp_e, input int exp_lat, input string tag);
    int n;
    if (sel_b) ifb.RSP_READY = 1'b1;
    else       ifa.RSP_READY = 1'b1;
    set_req(sel_b, 1'b1, addr);
    check({tag, "_req_ready"}, 32'(obs_ready(sel_b)), 32'd1);
    tick();
    set_req(sel_b, 1'b0, 32'hFFFF_FFFC);
    n = 0;
    while (!obs_valid(sel_b) && n < 8) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_data"}, obs_data(sel_b), exp_d);
    check({tag, "_err"}, 32'(obs_err(sel_b)), 32'(exp_e));
    tick();
    check({tag, "_valid_drop"}, 32'(obs_valid(sel_b)), 32'd0);
    check({tag, "_ready_back"}, 32'(obs_ready(sel_b)), 32'd1);
  endtask

  initial begin
    int start_cyc;
    checks = 0;
    errors = 0;
    RST    = 1'b1;
    ifa.REQ_VALID = 1'b0; ifa.REQ_ADDR = '0; ifa.RSP_READY = 1'b0;
    ifb.REQ_VALID = 1'b0; ifb.REQ_ADDR = '0; ifb.RSP_READY = 1'b0;
    a_load_en = 1'b0; a_load_addr = '0; a_load_data = '0;
    b_load_en = 1'b0; b_load_addr = '0; b_load_data = '0;
    tick();
    tick();

    // Program load while reset is held
    for (int i = 0; i < 12; i++) begin
      b_load_en   = 1'b1;
      b_load_addr = AW'(i);
      b_load_data = prog_word(i);
      a_load_en   = (i < 3);
      a_load_addr = (i == 0) ? AW'(0) : (i == 1) ? AW'(3) : AW'(5);
      a_load_data = (i == 0) ? 32'h1111_0000 : (i == 1) ? 32'h0020_81B3 : 32'hAAAA_5555;
      tick();
    end
    a_load_en = 1'b0;
    b_load_en = 1'b0;

    check("rst_req_ready", 32'(ifa.REQ_READY), 32'd0);
    check("rst_rsp_valid", 32'(ifa.RSP_VALID), 32'd0);
    check("rst_rsp_data",  ifa.RSP_DATA, 32'd0);
    check("rst_rsp_err",   32'(ifa.RSP_ERR), 32'd0);
    check("rst_state",     32'(a_state), 32'(S_IDLE));
    check("rst_b_valid",   32'(ifb.RSP_VALID), 32'd0);
    RST = 1'b0;
    #1;
    check("post_rst_ready_a", 32'(ifa.REQ_READY), 32'd1);
    check("post_rst_ready_b", 32'(ifb.REQ_READY), 32'd1);

    // Basic fetch and error responses
    fetch(1'b0, 32'h0000_000C, 32'h0020_81B3, 1'b0, 2, "t1_word3");
    fetch(1'b0, 32'h0000_000E, NOP_INSN, 1'b1, 2, "t2_misalign");
    fetch(1'b0, 32'h0000_0400, NOP_INSN, 1'b1, 2, "t2_range");

    // Response stall with request noise
    ifa.RSP_READY = 1'b0;
    set_req(1'b0, 1'b1, 32'h0000_000C);
    tick();
    set_req(1'b0, 1'b0, 32'h0);
    tick();
    tick();
    check("t3_valid_rise", 32'(ifa.RSP_VALID), 32'd1);
    for (int i = 0; i < 5; i++) begin
      set_req(1'b0, (i % 2) == 0, 32'h0000_0020 + 32'(i) * 32'd4);
      tick();
      check("t3_stall_valid", 32'(ifa.RSP_VALID), 32'd1);
      check("t3_stall_data",  ifa.RSP_DATA, 32'h0020_81B3);
      check("t3_stall_ready", 32'(ifa.REQ_READY), 32'd0);
      check("t3_stall_state", 32'(a_state), 32'(S_RESP));
    end
    set_req(1'b0, 1'b1, 32'h0000_0014);
    ifa.RSP_READY = 1'b1;
    tick();
    check("t3_consume_valid", 32'(ifa.RSP_VALID), 32'd0);
    check("t3_consume_state", 32'(a_state), 32'(S_IDLE));
    set_req(1'b0, 1'b0, 32'h0);

    // Load colliding with the read capture edge
    set_req(1'b0, 1'b1, 32'h0000_0014);
    tick();
    set_req(1'b0, 1'b0, 32'h0);
    tick();
    a_load_en   = 1'b1;
    a_load_addr = AW'(5);
    a_load_data = 32'hBBBB_6666;
    tick();
    a_load_en = 1'b0;
    check("t4_collide_valid", 32'(ifa.RSP_VALID), 32'd1);
    check("t4_collide_old",   ifa.RSP_DATA, 32'hAAAA_5555);
    check("t4_collide_err",   32'(ifa.RSP_ERR), 32'd0);
    tick();
    check("t4_collide_done",  32'(ifa.RSP_VALID), 32'd0);
    fetch(1'b0, 32'h0000_0014, 32'hBBBB_6666, 1'b0, 2, "t4_new");

    // Reset during the wait phase
    set_req(1'b0, 1'b1, 32'h0000_000C);
    tick();
    set_req(1'b0, 1'b0, 32'h0);
    check("t5_in_wait", 32'(a_state), 32'(S_WAIT));
    RST = 1'b1;
    tick();
    check("t5_rst_state", 32'(a_state), 32'(S_IDLE));
    check("t5_rst_ready", 32'(ifa.REQ_READY), 32'd0);
    check("t5_rst_valid", 32'(ifa.RSP_VALID), 32'd0);
    RST = 1'b0;
    #1;
    check("t5_ready_after", 32'(ifa.REQ_READY), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_no_rsp", 32'(ifa.RSP_VALID), 32'd0);
    end
    fetch(1'b0, 32'h0000_0000, 32'h1111_0000, 1'b0, 2, "t5_word0");

    // LATENCY=1 back-to-back fetches
    start_cyc = cyc;
    for (int i = 0; i < 12; i++) begin
      fetch(1'b1, 32'(i) * 32'd4, prog_word(i), 1'b0, 1, "t6_b2b");
    end
    check("t6_total_cycles", 32'(cyc - start_cyc), 32'd36);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
